// File: rtl/cb_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// cb_cfg_ctrl -- serial configuration controller for a daisy-chained set of
// connection boxes (CBs).
//
// A pass is requested with 'start'. The controller pulls config bytes over a
// valid/ready stream. It shifts each byte MSB first onto 'bit_in_CB', one bit
// per clock. At the first bit of every box it pulses the chain token
// 'cb_prgm_b' low. While a pass is running, 'prgm_b' is held low, so the
// fabric switches stay dead until the whole chain has been loaded.
//
// Optional feature, selected by the macro CB_CFG_CRC_EN:
//   The controller accumulates a CRC-8 (poly 0x07, init 0x00, MSB first)
//   over all data bytes. After the last data byte, one extra CRC byte is
//   accepted in the CHECK state. On a match the pass finishes. On a mismatch
//   the pass ends with error=1 and prgm_b=0.
//
// Ports:
//   clk        in   single clock
//   reset      in   synchronous, active-high
//   start      in   one-cycle pass request (ignored while busy)
//   abort      in   terminates a pass in progress (highest priority)
//   cfg_data   in   [7:0] config byte
//   cfg_valid  in   byte valid
//   cfg_ready  out  byte ready (LOAD / CHECK only)
//   bit_in_CB  out  serial config bit to the chain head
//   prgm_b     out  active-low global program mode
//   cb_prgm_b  out  active-low chain token, low on bit 0 of each box
//   cb_idx     out  index of the box currently being loaded
//   busy       out  pass in progress
//   done       out  last pass completed (held until next start/reset)
//   error      out  last pass aborted or failed its CRC
// ---------------------------------------------------------------------------
module cb_cfg_ctrl #(
  parameter int NUM_CB  = 4,
  parameter int CB_BITS = 48,
  localparam int IDX_W  = (NUM_CB > 1) ? $clog2(NUM_CB) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             bit_in_CB,
  output logic             prgm_b,
  output logic             cb_prgm_b,
  output logic [IDX_W-1:0] cb_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int BOX_BYTES   = CB_BITS / 8;
  localparam int TOTAL_BYTES = NUM_CB * BOX_BYTES;
  localparam int BYTE_W      = $clog2(TOTAL_BYTES + 1);
  localparam int BOX_W       = (BOX_BYTES > 1) ? $clog2(BOX_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef CB_CFG_CRC_EN
    CHECK,
`endif
    FINISH
  } state_t;

  state_t            state, state_next;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [BOX_W-1:0]  box_byte;

  // Strobes from the next-state logic to the datapath.
  logic launch;    // accepted start
  logic take;      // data byte handshake
  logic shift_en;  // one serial bit leaves this cycle
  logic finish;    // pass completed
  logic fail;      // abort or CRC mismatch

  logic last_byte;
  assign last_byte = (byte_cnt == BYTE_W'(TOTAL_BYTES - 1));

`ifdef CB_CFG_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Moore-style outputs decoded from the state registers.
`ifdef CB_CFG_CRC_EN
  assign cfg_ready = (state == LOAD) || (state == CHECK);
`else
  assign cfg_ready = (state == LOAD);
`endif
  assign bit_in_CB = (state == SHIFT) && shreg[7];
  assign cb_prgm_b = !((state == SHIFT) && (bit_cnt == 3'd0) &&
                       (box_byte == '0));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    take       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        // Abort beats a coincident start: nothing is launched.
        if (start && !abort) begin
          state_next = LOAD;
          launch     = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          fail       = 1'b1;
        end else if (cfg_valid) begin
          state_next = SHIFT;
          take       = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
          fail       = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef CB_CFG_CRC_EN
            state_next = last_byte ? CHECK : LOAD;
`else
            state_next = last_byte ? FINISH : LOAD;
`endif
          end
        end
      end
`ifdef CB_CFG_CRC_EN
      CHECK: begin
        if (abort) begin
          state_next = IDLE;
          fail       = 1'b1;
        end else if (cfg_valid) begin
          if (cfg_data == crc) begin
            state_next = FINISH;
          end else begin
            state_next = IDLE;
            fail       = 1'b1;
          end
        end
      end
`endif
      FINISH: begin
        state_next = IDLE;
        if (abort) fail   = 1'b1;
        else       finish = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      box_byte <= '0;
      cb_idx   <= '0;
      prgm_b   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef CB_CFG_CRC_EN
      crc      <= '0;
`endif
    end else begin
      if (launch) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        box_byte <= '0;
        cb_idx   <= '0;
        prgm_b   <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
`ifdef CB_CFG_CRC_EN
        crc      <= '0;
`endif
      end
      if (take) begin
        shreg   <= cfg_data;
        bit_cnt <= '0;
`ifdef CB_CFG_CRC_EN
        crc     <= crc8_next(crc, cfg_data);
`endif
      end
      if (shift_en) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_cnt <= byte_cnt + BYTE_W'(1);
          if (box_byte == BOX_W'(BOX_BYTES - 1)) begin
            box_byte <= '0;
            // The last box keeps its index, so cb_idx reads NUM_CB-1 after a pass.
            if (cb_idx != IDX_W'(NUM_CB - 1)) cb_idx <= cb_idx + IDX_W'(1);
          end else begin
            box_byte <= box_byte + BOX_W'(1);
          end
        end
      end
      if (finish) begin
        prgm_b <= 1'b1;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
      if (fail) begin
        // The fabric is left unprogrammed: prgm_b stays low.
        prgm_b <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
        error  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cb_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cb_cfg_ctrl -- self-checking bench for cb_cfg_ctrl.
// Configuration: NUM_CB=2, CB_BITS=48 (12 bytes, 96 serial bits).
// Expected serial stream, token and box index come from a reference model
// derived directly from the byte array. Inputs are driven on the falling
// edge and outputs are sampled there too. The CRC scenario is compiled
// only with CB_CFG_CRC_EN.
// ---------------------------------------------------------------------------
module tb_cb_cfg_ctrl;

  localparam int NUM_CB  = 2;
  localparam int CB_BITS = 48;
  localparam int NBYTES  = NUM_CB * CB_BITS / 8;
  localparam int NBITS   = NBYTES * 8;
  localparam int IDX_W   = 1;
`ifdef CB_CFG_CRC_EN
  localparam int EXP_DONE = 9 * NBYTES + 2;
`else
  localparam int EXP_DONE = 9 * NBYTES + 1;
`endif

  logic             clk = 1'b0;
  logic             reset, start, abort, cfg_valid;
  logic [7:0]       cfg_data;
  logic             cfg_ready, bit_in_CB, prgm_b, cb_prgm_b;
  logic [IDX_W-1:0] cb_idx;
  logic             busy, done, error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0, done_cyc;

  logic [7:0]       data_mem [NBYTES];
  logic [NBITS-1:0] cap_bits, cap_tok, cap_idx;

  cb_cfg_ctrl #(.NUM_CB(NUM_CB), .CB_BITS(CB_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .bit_in_CB(bit_in_CB), .prgm_b(prgm_b), .cb_prgm_b(cb_prgm_b),
    .cb_idx(cb_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [NBITS-1:0] model_bits();
    logic [NBITS-1:0] r;
    for (int i = 0; i < NBITS; i++) r[i] = data_mem[i / 8][7 - (i % 8)];
    return r;
  endfunction

  function automatic logic [NBITS-1:0] model_tok();
    logic [NBITS-1:0] r;
    for (int i = 0; i < NBITS; i++) r[i] = ((i % CB_BITS) == 0) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic [NBITS-1:0] model_idx();
    logic [NBITS-1:0] r;
    for (int i = 0; i < NBITS; i++) r[i] = ((i / CB_BITS) % 2) == 1;
    return r;
  endfunction

  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int b = 0; b < NBYTES; b++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ data_mem[b][i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_random();
    for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'($urandom);
  endtask

  task automatic do_start(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cfg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, g);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 60) begin
      @(negedge clk);
      g++;
    end
    start    = 1'b0;
    done_cyc = done ? (cyc - t0) : -1;
  endtask

  // Streams all bytes. kill_kind: 0 none, 1 abort, 2 reset, at bit 3 of kill_byte.
  task automatic stream(input int stall_idx, input int stall_len,
                        input int kill_byte, input int kill_kind,
                        input bit bad_crc);
    int bitn = 0;
    cap_bits = '0;
    cap_tok  = '1;
    cap_idx  = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b == stall_idx) begin
        cfg_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      cfg_data  = data_mem[b];
      cfg_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        cap_bits[bitn] = bit_in_CB;
        cap_tok[bitn]  = cb_prgm_b;
        cap_idx[bitn]  = cb_idx[0];
        bitn++;
        if (b == kill_byte && k == 3 && kill_kind != 0) begin
          if (kill_kind == 1) abort = 1'b1;
          else                reset = 1'b1;
          @(negedge clk);
          return;
        end
        @(negedge clk);
      end
    end
    cfg_valid = 1'b0;
`ifdef CB_CFG_CRC_EN
    cfg_data  = bad_crc ? (model_crc() ^ 8'h5A) : model_crc();
    cfg_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    cfg_valid = 1'b0;
`else
    if (bad_crc) cfg_data = 8'h00;
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bit_in_CB, prgm_b, cb_prgm_b, cb_idx, cfg_ready, busy, done, error} !== 8'b01100000) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 01100000",
               {bit_in_CB, prgm_b, cb_prgm_b, cb_idx, cfg_ready, busy, done, error});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_pass(input string name, input int exp_cyc);
    checks++;
    if (cap_bits !== model_bits()) begin
      errors++;
      $display("FAIL %s_bits: got %h, expected %h", name, cap_bits, model_bits());
    end
    checks++;
    if (cap_tok !== model_tok()) begin
      errors++;
      $display("FAIL %s_token: got %h, expected %h", name, cap_tok, model_tok());
    end
    checks++;
    if (cap_idx !== model_idx()) begin
      errors++;
      $display("FAIL %s_cb_idx_seq: got %h, expected %h", name, cap_idx, model_idx());
    end
    checks++;
    if (done_cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d, expected %0d", name, done_cyc, exp_cyc);
    end
    checks++;
    if ({prgm_b, busy, error, cb_idx} !== 4'b1001) begin
      errors++;
      $display("FAIL %s_end_status: prgm_b/busy/error/cb_idx got %b, expected 1001",
               name, {prgm_b, busy, error, cb_idx});
    end
  endtask

  task automatic test_nominal();
    fill_random();
    do_start(1'b0);
    checks++;
    if ({prgm_b, busy, done, error, cfg_ready} !== 5'b01001) begin
      errors++;
      $display("FAIL start_status: got %b, expected 01001", {prgm_b, busy, done, error, cfg_ready});
    end
    stream(-1, 0, -1, 0, 1'b0);
    wait_done();
    check_pass("nominal", EXP_DONE);
  endtask

  task automatic test_stall();
    fill_random();
    do_start(1'b0);
    stream(3, 5, -1, 0, 1'b0);
    wait_done();
    check_pass("stall", EXP_DONE + 5);
  endtask

  task automatic test_abort();
    fill_random();
    do_start(1'b0);
    stream(-1, 0, 7, 1, 1'b0);
    abort = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if ({error, prgm_b, busy, cfg_ready, done} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_status: error/prgm_b/busy/ready/done got %b, expected 10000",
               {error, prgm_b, busy, cfg_ready, done});
    end
    // Restart clears the error and a complete pass follows.
    fill_random();
    do_start(1'b0);
    checks++;
    if ({error, busy} !== 2'b01) begin
      errors++;
      $display("FAIL abort_restart: error/busy got %b, expected 01", {error, busy});
    end
    stream(-1, 0, -1, 0, 1'b0);
    wait_done();
    check_pass("after_abort", EXP_DONE);
  endtask

  task automatic test_abort_priority();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, cfg_ready, prgm_b} !== 3'b001) begin
      errors++;
      $display("FAIL abort_vs_start: busy/ready/prgm_b got %b, expected 001", {busy, cfg_ready, prgm_b});
    end
    do_start(1'b0);
    cfg_data = 8'hFF; cfg_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({error, busy, cfg_ready, bit_in_CB, prgm_b} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_vs_handshake: got %b, expected 10000",
               {error, busy, cfg_ready, bit_in_CB, prgm_b});
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    fill_random();
    do_start(1'b0);
    stream(-1, 0, 4, 2, 1'b0);
    checks++;
    if ({bit_in_CB, prgm_b, cb_prgm_b, cb_idx, cfg_ready, busy, done, error} !== 8'b01100000) begin
      errors++;
      $display("FAIL reset_mid_state: got %b, expected 01100000",
               {bit_in_CB, prgm_b, cb_prgm_b, cb_idx, cfg_ready, busy, done, error});
    end
    reset = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_ready !== 1'b0 || busy !== 1'b0 || bit_in_CB !== 1'b0) quiet = 1'b0;
    end
    cfg_valid = 1'b0;
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_valid_ignored: idle_quiet got %b, expected 1", quiet);
    end
  endtask

  task automatic test_start_held();
    fill_random();
    do_start(1'b1);
    stream(-1, 0, -1, 0, 1'b0);
    wait_done();
    check_pass("start_held", EXP_DONE);
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, cb_idx} !== 3'b011) begin
      errors++;
      $display("FAIL start_held_single: busy/done/cb_idx got %b, expected 011", {busy, done, cb_idx});
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      fill_random();
      do_start(1'b0);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done_cleared: done got %b, expected 0", done);
      end
      stream(-1, 0, -1, 0, 1'b0);
      wait_done();
      check_pass("back_to_back", EXP_DONE);
    end
  endtask

`ifdef CB_CFG_CRC_EN
  task automatic test_crc();
    for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'(i);
    do_start(1'b0);
    stream(-1, 0, -1, 0, 1'b0);
    wait_done();
    check_pass("crc_good", EXP_DONE);
    do_start(1'b0);
    stream(-1, 0, -1, 0, 1'b1);
    checks++;
    if ({error, prgm_b, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL crc_bad: error/prgm_b/busy/done got %b, expected 1000",
               {error, prgm_b, busy, done});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_abort_priority();
    test_start_held();
    test_back_to_back();
`ifdef CB_CFG_CRC_EN
    test_crc();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
